// File: rtl/boot_pkg.sv
// Shared types and sizing helpers for the boot loader slice.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int unsigned DEF_WORD_SIZE  = 16;
  localparam int unsigned DEF_ADDR_SIZE  = 8;
  localparam int unsigned IMAGE_WORDS    = 2 ** (DEF_ADDR_SIZE - 1);
  localparam int unsigned BYTES_PER_WORD = DEF_WORD_SIZE / 8;
  localparam int unsigned IMAGE_BYTES    = IMAGE_WORDS * BYTES_PER_WORD;

  function automatic int unsigned image_words(input int unsigned addr_size);
    return 2 ** (addr_size - 1);
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned word_size);
    return word_size / 8;
  endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Little-endian byte-to-word assembly; word_valid_c strobes with the last lane's byte.
module byte_packer
  import boot_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic [WORD_SIZE-1:0] word_c,
  output logic                 word_valid_c
);

  localparam int unsigned BPW    = bytes_per_word(WORD_SIZE);
  localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LANE_W-1:0]    lane;
  logic [WORD_SIZE-1:0] pack;
  logic                 last_lane_c;

  assign last_lane_c = (lane == LANE_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      pack <= '0;
    end else if (byte_valid) begin
      pack[{lane, 3'b000} +: 8] <= byte_data;
      lane <= last_lane_c ? '0 : LANE_W'(lane + LANE_W'(1));
    end
  end

  // Completed word includes the byte arriving this cycle in its lane.
  always_comb begin
    word_c                    = pack;
    word_c[{lane, 3'b000} +: 8] = byte_data;
    word_valid_c              = byte_valid && last_lane_c;
  end

endmodule

// File: rtl/boot_loader.sv
// Boot image loader: streams bytes into an image buffer, then feeds the CPU boot sweep.
// Optional trailing XOR checksum enabled by defining BOOT_CHECKSUM_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] addr_bus,
  input  logic                 wr_en,
  input  logic                 boot_done_flag,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  output logic                 cpu_rst,
  output logic                 load_done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   byte_count
);

  localparam int unsigned NWORDS = image_words(ADDR_SIZE);
  localparam int unsigned BPW    = bytes_per_word(WORD_SIZE);
  localparam int unsigned NBYTES = NWORDS * BPW;
  localparam int unsigned CNT_W  = ADDR_SIZE + 1;
  localparam int unsigned IDX_W  = ADDR_SIZE - 1;
`ifdef BOOT_CHECKSUM_EN
  localparam int unsigned LOAD_BYTES = NBYTES + 1;
`else
  localparam int unsigned LOAD_BYTES = NBYTES;
`endif

  state_t state, state_next;

  logic [WORD_SIZE-1:0] image [NWORDS];
  logic                 accept_c;
  logic                 image_byte_c;
  logic                 last_c;
  logic                 csum_ok_c;
  logic                 drive_c;
  logic [WORD_SIZE-1:0] word_c;
  logic                 word_valid_c;
  logic [IDX_W-1:0]     word_idx_c;
  logic                 addr_lsb_unused;

  assign addr_lsb_unused = addr_bus[0];

  assign accept_c     = in_valid && in_ready;
  assign image_byte_c = accept_c && (byte_count < CNT_W'(NBYTES));
  assign last_c       = accept_c && (byte_count == CNT_W'(LOAD_BYTES - 1));
  assign word_idx_c   = IDX_W'(byte_count / CNT_W'(BPW));

  byte_packer #(.WORD_SIZE(WORD_SIZE)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (image_byte_c),
    .byte_data    (in_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Image buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (word_valid_c) image[word_idx_c] <= word_c;
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst)               csum <= '0;
    else if (image_byte_c) csum <= csum ^ in_data;
  end

  assign csum_ok_c = (in_data == csum);
`else
  assign csum_ok_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (last_c) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = csum_ok_c ? RELEASE : ERROR;
`else
          state_next = csum_ok_c ? RELEASE : LOAD;
`endif
        end
      end
      RELEASE: if (boot_done_flag) state_next = RUN;
      RUN:     state_next = RUN;
`ifdef BOOT_CHECKSUM_EN
      ERROR:   state_next = ERROR;
`endif
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    drive_c  = 1'b0;
    case (state)
      LOAD:    in_ready = 1'b1;
      RELEASE: drive_c  = wr_en && !boot_done_flag && !cpu_rst;
      default: ;
    endcase
  end

  // Registered status: cpu_rst drops on the same edge that enters RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      byte_count <= '0;
    end else begin
      cpu_rst    <= !((state_next == RELEASE) || (state_next == RUN));
      load_done  <= load_done || last_c;
      if (accept_c) byte_count <= CNT_W'(byte_count + CNT_W'(1));
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) error <= 1'b0;
    else     error <= (state_next == ERROR);
  end
`else
  assign error = 1'b0;
`endif

  assign data_bus = drive_c ? image[addr_bus[ADDR_SIZE-1:1]] : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: queue-based model compared every cycle plus literal pins.
// Covers the BOOT_CHECKSUM_EN build when that macro is defined.
module tb_boot_loader;

  localparam int unsigned NB = 256;
`ifdef BOOT_CHECKSUM_EN
  localparam int unsigned NTOT = NB + 1;
`else
  localparam int unsigned NTOT = NB;
`endif
  localparam logic [15:0] FLOAT = 16'hFFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] addr_bus = 8'h00;
  logic       wr_en = 1'b0;
  logic       boot_done_flag = 1'b0;
  wire [15:0] data_bus;
  logic       in_ready, cpu_rst, load_done, error;
  logic [8:0] byte_count;

  pullup (data_bus);

  always #5 clk = ~clk;

  boot_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .addr_bus       (addr_bus),
    .wr_en          (wr_en),
    .boot_done_flag (boot_done_flag),
    .data_bus       (data_bus),
    .cpu_rst        (cpu_rst),
    .load_done      (load_done),
    .error          (error),
    .byte_count     (byte_count)
  );

  // Model: the bytes received so far, and whether the CPU has finished its sweep.
  logic [7:0] q[$];
  bit         m_run = 1'b0;
  bit         checking = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic bit m_sum_ok();
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < int'(NB); i++) x ^= q[i];
    return x == q[NB];
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_run = 1'b0;
    end else if (q.size() < NTOT) begin
      if (in_valid) q.push_back(in_data);
    end else if (m_sum_ok() && boot_done_flag) begin
      m_run = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit         full = (q.size() == NTOT);
    bit         released = full && m_sum_ok();
    logic [15:0] exp_bus = FLOAT;
    int         a = int'(addr_bus) >> 1;
    if (released && !m_run && wr_en && !boot_done_flag) exp_bus = {q[2*a+1], q[2*a]};
    check("in_ready",   32'(in_ready),   32'(!full));
    check("cpu_rst",    32'(cpu_rst),    32'(!released));
    check("load_done",  32'(load_done),  32'(full));
    check("error",      32'(error),      32'(full && !released));
    check("byte_count", 32'(byte_count), 32'(q.size()));
    check("data_bus",   32'(data_bus),   32'(exp_bus));
  endtask

  task automatic tick();
    @(negedge clk);
    if (checking) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int gap, input logic [7:0] mask, input logic [7:0] trailer);
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
        tick();
      end
      in_valid = 1'b1;
      in_data  = (k < int'(NB)) ? (8'(k) ^ mask) : trailer;
      wr_en    = k[0];
      addr_bus = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    wr_en    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    checking = 1'b1;
    tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_count",   32'(byte_count), 32'd0);
    check("rst_ready",   32'(in_ready), 32'd1);
    check("rst_bus",     32'(data_bus), 32'(FLOAT));
    rst = 1'b0;

    // Full back-to-back load, trailer (if any) is the correct XOR of 0.
    load(NTOT, 0, 8'h00, 8'h00);
    check("load_done", 32'(load_done), 32'd1);
    check("load_cpu_rst", 32'(cpu_rst), 32'd0);
    check("load_count", 32'(byte_count), 32'(NTOT));

    // Boot drive
    addr_bus = 8'h10; wr_en = 1'b1; #1;
    check("bus_10", 32'(data_bus), 32'h1110);
    tick();
    wr_en = 1'b0; #1;
    check("bus_wr0", 32'(data_bus), 32'(FLOAT));
    addr_bus = 8'h11; wr_en = 1'b1; #1;
    check("bus_11", 32'(data_bus), 32'h1110);
    addr_bus = 8'hFE; #1;
    check("bus_fe", 32'(data_bus), 32'hFFFE);
    for (int a = 0; a < 256; a++) begin
      addr_bus = 8'(a);
      tick();
    end

    // Handover, then bytes offered in RUN are ignored.
    boot_done_flag = 1'b1; #1;
    check("bus_flag", 32'(data_bus), 32'(FLOAT));
    tick();
    boot_done_flag = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; addr_bus = 8'h20;
    repeat (4) tick();
    in_valid = 1'b0;
    check("run_count", 32'(byte_count), 32'(NTOT));
    check("run_bus",   32'(data_bus), 32'(FLOAT));

    // Reset from RUN, then throttled load with an inverted pattern.
    rst = 1'b1; tick();
    check("rst_run_cpu", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    load(NTOT, 2, 8'hFF, 8'h00);
    addr_bus = 8'h10; wr_en = 1'b1; #1;
    check("thr_bus_10", 32'(data_bus), 32'hEEEF);
    for (int a = 0; a < 256; a += 7) begin
      addr_bus = 8'(a);
      tick();
    end

    // Reset while in RELEASE, then reset mid-load after 100 bytes.
    rst = 1'b1; tick();
    check("rst_rel_cpu", 32'(cpu_rst), 32'd1);
    check("rst_rel_cnt", 32'(byte_count), 32'd0);
    rst = 1'b0;
    load(100, 0, 8'h3C, 8'h00);
    check("mid_count", 32'(byte_count), 32'd100);
    rst = 1'b1; tick();
    check("mid_rst_cnt", 32'(byte_count), 32'd0);
    check("mid_rst_cpu", 32'(cpu_rst), 32'd1);
    rst = 1'b0;

`ifdef BOOT_CHECKSUM_EN
    load(NTOT, 0, 8'h00, 8'h01);
    repeat (2) tick();
    check("csum_error", 32'(error), 32'd1);
    check("csum_cpu",   32'(cpu_rst), 32'd1);
    check("csum_ready", 32'(in_ready), 32'd0);
`else
    load(NTOT, 1, 8'h3C, 8'h00);
    addr_bus = 8'h00; wr_en = 1'b1; #1;
    check("mask_bus_00", 32'(data_bus), 32'h3D3C);
    tick();
`endif
    wr_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
